// File: rtl/stream_demux_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_if
// Purpose  : Producer/consumer bundle for the 1-to-NCH stream demultiplexer.
// Revision : 1.0
// ============================================================================
interface stream_demux_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);

    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_sel;
    logic                 in_bcast;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*WIDTH-1:0] out_data;
    logic [NCH-1:0]       out_valid;
    logic [NCH-1:0]       out_ready;
    logic [7:0]           err_cnt;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err_cnt
    );

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux
// Purpose  : Registered 1-to-NCH stream demux with broadcast and drop count.
// Revision : 1.0
// ============================================================================
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    stream_demux_if.slave  bus
);
    localparam int SELW = $clog2(NCH);

    logic [NCH-1:0]       w_free;
    logic [NCH-1:0]       w_sel_oh;
    logic [NCH-1:0]       w_load;
    logic                 w_sel_legal;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_drop;

    logic [NCH-1:0]       r_valid;
    logic [NCH*WIDTH-1:0] r_data;
    logic [7:0]           r_err_cnt;

    // One-hot decode; an out-of-range select decodes to all zeros.
    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            w_sel_oh[i] = (bus.in_sel == SELW'(i));
        end
    end

    assign w_free      = ~r_valid | bus.out_ready;
    assign w_sel_legal = |w_sel_oh;
    assign w_in_ready  = bus.in_bcast  ? (&w_free)
                       : w_sel_legal   ? (|(w_sel_oh & w_free))
                       :                 1'b1;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_load      = w_accept ? (bus.in_bcast ? {NCH{1'b1}} : w_sel_oh) : '0;
    assign w_drop      = w_accept & ~bus.in_bcast & ~w_sel_legal;

    // A load wins over a drain so a slot can be refilled while it empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_load[i]) begin
                    r_valid[i]                <= 1'b1;
                    r_data[i*WIDTH +: WIDTH]  <= bus.in_data;
                end else if (bus.out_ready[i]) begin
                    r_valid[i]                <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_drop && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-NCH stream demultiplexer with per-channel valid/ready handshakes, broadcast mode and illegal-select accounting. Each accepted input word is routed to one output channel, or to all channels in broadcast mode, and held in a one-entry output register until that channel's consumer takes it. It is the sequential successor to the lecture's combinational select blocks, and sits between a single producer stream and NCH independent consumers.

## Interface
- WIDTH, default 8: data width in bits per word.
- NCH, default 4: number of output channels, minimum 2.
- SELW, default $clog2(NCH): select width; a localparam derived from NCH, not overridable.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  SELW  destination channel index; ignored when in_bcast=1.
- in_bcast  input  1  1 = deliver the word to every channel.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- out_data  output  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  NCH  channel i slot holds a word.
- out_ready  input  NCH  consumer i takes the word.
- err_cnt  output  8  count of dropped words with in_sel >= NCH; saturates at 255.

## Operation
- Each channel i has one slot (out_valid[i], data[i]).
- free[i] = !out_valid[i] || out_ready[i]. A slot being drained this cycle can be reloaded in the same cycle.
- in_ready is combinational from in_bcast, in_sel, out_valid and out_ready:
  - in_bcast=1: AND of all free[i]. Broadcast is all-or-nothing; there is no partial delivery.
  - in_bcast=0, in_sel < NCH: free[in_sel].
  - in_bcast=0, in_sel >= NCH: 1. The word is always accepted and then dropped. This is reachable only when NCH is not a power of 2.
- in_ready does not depend on in_valid.
- accept = in_valid && in_ready.
- On accept:
  - in_bcast=1: every slot loads in_data and sets out_valid to 1.
  - Legal in_sel: only slot in_sel loads and sets valid. Other slots are unaffected.
  - Illegal in_sel: no slot changes. err_cnt increments, saturating at 255; 255 plus a drop stays 255.
- Slot i clears (out_valid[i] goes to 0) when out_valid[i] && out_ready[i] and slot i is not loaded in the same cycle.
- Load and drain in the same cycle on the same slot: the new word replaces the old one and out_valid stays 1.
- out_data[i] holds its value while out_valid[i]=1. Its value when out_valid[i]=0 is the last loaded word (0 after reset), and consumers ignore it.
- Output ordering per channel is strictly the input acceptance order. There is no ordering guarantee across channels.

## Timing
- Latency: a word accepted at edge N appears with out_valid high after edge N, i.e. in cycle N+1.
- Throughput: 1 word/cycle per channel when out_ready is held at 1. The aggregate is also 1 word/cycle, since there is a single input.
- Backpressure: a stalled channel blocks only words addressed to it and broadcasts. Traffic to other channels proceeds.
- Reset asserted (asynchronous, immediately, regardless of clk):
  - out_valid = 0, out_data = 0, err_cnt = 0.
  - Pending words are discarded.
  - in_ready during reset follows the combinational rule with all slots free, which may read as 1. The producer must not treat it as acceptance; no state changes while rst=1.
- Reset deassertion: normal operation from the first rising edge with rst=0.
- in_valid=1 with in_ready=0: the producer must hold in_data, in_sel and in_bcast stable until accepted.

## Test plan
- Reset then routing, with WIDTH=8, NCH=4 and all out_ready=1: send 8'hA0..8'hA3 with sel 0..3 on consecutive cycles. Expect out_valid one-hot 0001, 0010, 0100, 1000 one cycle after each accept, data matching, and in_ready=1 throughout.
- Backpressure: out_ready[2]=0, send 8'h11 to sel 2 and then 8'h22 to sel 2. Expect the first accepted, in_ready=0 for the second while slot 2 is full, and 8'h11 held. Raise out_ready[2]; expect 8'h22 accepted in that same cycle and visible the next cycle. Sends to sel 1 during the stall are accepted.
- Broadcast: out_ready=4'b1011 with slot 2 full, send 8'h5A with bcast=1. Expect in_ready=0 and no slot changed. Drain slot 2; then expect the broadcast accepted and all four out_valid=1 with data 8'h5A.
- Illegal select with NCH=3 and SELW=2: send sel=3 300 times. Expect in_ready=1 each time, no out_valid change, and err_cnt = 255 (saturated) rather than 44.
- Simultaneous load and drain on channel 0 with out_ready[0]=1 and back-to-back words 1, 2, 3. Expect out_valid[0] to stay 1 continuously and the consumer to see 1, 2, 3 with no bubbles.
- Reset mid-operation: with slots 0 and 3 full and err_cnt=5, assert rst between clock edges. Expect out_valid=0, err_cnt=0 and out_data=0 immediately. After deassertion, a new send to sel 3 completes normally.
